oled_digit_column_streamer: RTL and testbench
=============================================

Name: oled_digit_column_streamer

Overview:
- Frame-level sequencer that feeds the 7-segment-to-pixel-column decoder for a row of large digits and streams the result to the SSD1306 link.
- On `start`, it first emits the SSD1306 column/page addressing commands.
- It then walks page → digit → column, driving the decoder's digit segments and x/y indices, and forwards each returned 8-pixel column byte over a valid/ready byte interface to the I2C/SPI transmitter.

Parameters:
- NUM_DIGITS, 6, digits per frame.
- DIGIT_WIDTH, 21, columns per digit cell, including leading space.
- PAGES, 4, 8-pixel pages per digit (32 px tall).
- COL_START, 0, first display column written.
- PAGE_START, 0, first display page written.
- SEG_W, 8, width of one digit's segment vector.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin a frame.
- segments_in  in  NUM_DIGITS*SEG_W  digit i at bits [i*SEG_W +: SEG_W]; digit 0 is leftmost.
- segments_out  out  SEG_W  to decoder: segments of the current digit.
- index_x  out  5  to decoder: column within the cell, 0..DIGIT_WIDTH-1.
- index_y  out  2  to decoder: page within the cell, 0..PAGES-1.
- pixels_column_in  in  8  from decoder; combinational function of segments_out, index_x and index_y.
- tx_data  out  8  byte to the link.
- tx_is_cmd  out  1  1 = command byte (D/C low), 0 = GDDRAM data.
- tx_valid  out  1  byte available.
- tx_ready  in  1  link accepts the byte.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async assert, sync release). All outputs 0: tx_valid, tx_data, tx_is_cmd, busy, frame_done, index_x, index_y, segments_out. State = IDLE; all counters 0.
- States: IDLE → CMD → DATA → DONE → IDLE.
- IDLE:
  - On start=1, snapshot segments_in into an internal register, clear counters, go to CMD.
  - Changes to segments_in after this have no effect until the next frame.
- CMD: sends 6 bytes, tx_is_cmd=1, in this order:
  - 0x21
  - COL_START
  - COL_START + NUM_DIGITS*DIGIT_WIDTH - 1 (8-bit truncation)
  - 0x22
  - PAGE_START
  - PAGE_START + PAGES - 1
- DATA: sends PAGES*NUM_DIGITS*DIGIT_WIDTH bytes, tx_is_cmd=0.
  - Order: page outer, digit middle, column inner. This matches SSD1306 horizontal addressing.
  - Byte k carries pixels_column_in sampled with index_y=page, segments_out=snapshot[digit], index_x=col.
- Handshake:
  - A byte transfers on a rising edge with tx_valid && tx_ready.
  - tx_data and tx_is_cmd are registered and held stable while tx_valid && !tx_ready.
  - tx_valid never drops without a transfer, except on reset.
- Timing and throughput:
  - First command byte is valid the cycle after start is sampled.
  - At the edge that transfers a byte, the next byte is loaded, so with tx_ready tied high the block sends one byte per cycle.
  - CMD→DATA has no bubble.
  - The decoder outputs (segments_out, index_x, index_y) always point at the byte to be loaded next. The decoder adds no pipeline stage.
- Counters:
  - col wraps DIGIT_WIDTH-1 → 0 and increments digit.
  - digit wraps NUM_DIGITS-1 → 0 and increments page.
  - The transfer of the byte at page=PAGES-1, digit=NUM_DIGITS-1, col=DIGIT_WIDTH-1 moves to DONE with tx_valid=0.
- DONE: frame_done=1 for exactly one cycle, busy falls in the same cycle, then IDLE.
  - A start arriving in DONE is ignored.
- start while busy or in DONE: ignored; no restart, no queuing.
- Reset mid-frame: immediate abort. tx_valid drops asynchronously; no frame_done. The next start begins a fresh command sequence.
- tx_ready asserted while tx_valid=0: no effect.

Test Plan:
- Reset defaults: assert rst_n=0 mid-frame, at a point where tx_valid=1 → tx_valid, busy and frame_done are 0 immediately, with no clock edge. After release with no start, outputs stay idle for 10 cycles.
- Full frame, tx_ready=1, defaults:
  - First 6 bytes are 0x21,0x00,0x7D,0x22,0x00,0x03 with tx_is_cmd=1.
  - Then 504 data bytes, tx_is_cmd=0, on consecutive cycles.
  - frame_done pulses 511 cycles after start.
- Ordering: use a decoder model returning {index_y, index_x} and drive per-digit-distinct segments.
  - Data byte 0 = page 0, digit 0, col 0.
  - Data byte 21 = digit 1, col 0.
  - Data byte 126 = page 1, digit 0.
  - segments_out matches the digit snapshot at each byte.
- Backpressure: random tx_ready with about 30% duty → tx_data and tx_is_cmd are stable while stalled. The byte sequence is identical to the tx_ready=1 run.
- Snapshot and start rules:
  - Change segments_in and pulse start at data byte 100 → stream unchanged, no restart, single frame_done.
  - A second start after frame_done → a new frame uses the new segments.

Source files
------------

// File: rtl/oled_digit_column_streamer_if.sv
// Byte link between the frame sequencer and the SSD1306 I2C/SPI transmitter.
// One byte moves on a clock edge where tx_valid and tx_ready are both high.
interface oled_digit_column_streamer_if;
    logic [7:0] tx_data;
    logic       tx_is_cmd;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_is_cmd,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_is_cmd,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/oled_digit_column_streamer.sv
// Streams one frame of large 7-segment digits to an SSD1306:
// addressing commands first, then page/digit/column pixel bytes.
module oled_digit_column_streamer #(
    parameter int NUM_DIGITS  = 6,
    parameter int DIGIT_WIDTH = 21,
    parameter int PAGES       = 4,
    parameter int COL_START   = 0,
    parameter int PAGE_START  = 0,
    parameter int SEG_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_DIGITS*SEG_W-1:0] segments_in,
    output logic [SEG_W-1:0]            segments_out,
    output logic [4:0]                  index_x,
    output logic [1:0]                  index_y,
    input  logic [7:0]                  pixels_column_in,
    oled_digit_column_streamer_if.master tx,
    output logic                        busy,
    output logic                        frame_done
);
    localparam int DB = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int COL_END  = COL_START + NUM_DIGITS * DIGIT_WIDTH - 1;
    localparam int PAGE_END = PAGE_START + PAGES - 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t                      r_state, w_state_nxt;
    logic                        r_valid, w_valid_nxt;
    logic [7:0]                  r_data, w_data_nxt;
    logic                        r_cmd, w_cmd_nxt;
    logic [2:0]                  r_cmd_idx, w_cmd_idx_nxt;
    logic [4:0]                  r_col, w_col_nxt;
    logic [DB-1:0]               r_dig, w_dig_nxt;
    logic [1:0]                  r_page, w_page_nxt;
    logic                        r_last, w_last_nxt;
    logic [NUM_DIGITS*SEG_W-1:0] r_snap, w_snap_nxt;

    logic       w_xfer;
    logic       w_load_pix;
    logic       w_col_wrap;
    logic       w_dig_wrap;
    logic       w_at_end;
    logic [7:0] w_cmd_rom;

    assign w_xfer     = r_valid && tx.tx_ready;
    assign w_col_wrap = (r_col == 5'(DIGIT_WIDTH - 1));
    assign w_dig_wrap = (r_dig == DB'(NUM_DIGITS - 1));
    assign w_at_end   = w_col_wrap && w_dig_wrap &&
                        (r_page == 2'(PAGES - 1));

    always_comb begin
        case (r_cmd_idx)
            3'd0:    w_cmd_rom = 8'h21;
            3'd1:    w_cmd_rom = 8'(COL_START);
            3'd2:    w_cmd_rom = 8'(COL_END);
            3'd3:    w_cmd_rom = 8'h22;
            3'd4:    w_cmd_rom = 8'(PAGE_START);
            3'd5:    w_cmd_rom = 8'(PAGE_END);
            default: w_cmd_rom = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_valid;
        w_data_nxt    = r_data;
        w_cmd_nxt     = r_cmd;
        w_cmd_idx_nxt = r_cmd_idx;
        w_col_nxt     = r_col;
        w_dig_nxt     = r_dig;
        w_page_nxt    = r_page;
        w_last_nxt    = r_last;
        w_snap_nxt    = r_snap;
        w_load_pix    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_CMD;
                    w_snap_nxt    = segments_in;
                    w_col_nxt     = '0;
                    w_dig_nxt     = '0;
                    w_page_nxt    = '0;
                    w_last_nxt    = 1'b0;
                    w_valid_nxt   = 1'b1;
                    w_cmd_nxt     = 1'b1;
                    w_data_nxt    = 8'h21;
                    w_cmd_idx_nxt = 3'd1;
                end
            end
            S_CMD: begin
                if (w_xfer) begin
                    if (r_cmd_idx == 3'd6) begin
                        w_state_nxt = S_DATA;
                        w_load_pix  = 1'b1;
                    end else begin
                        w_data_nxt    = w_cmd_rom;
                        w_cmd_idx_nxt = r_cmd_idx + 3'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    if (r_last) begin
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_load_pix = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // counters always point at the byte to be loaded next
        if (w_load_pix) begin
            w_data_nxt = pixels_column_in;
            w_cmd_nxt  = 1'b0;
            w_last_nxt = w_at_end;
            w_col_nxt  = w_col_wrap ? 5'd0 : r_col + 5'd1;
            if (w_col_wrap) begin
                w_dig_nxt = w_dig_wrap ? '0 : r_dig + DB'(1);
                if (w_dig_wrap) begin
                    w_page_nxt = (r_page == 2'(PAGES - 1)) ? 2'd0
                                                           : r_page + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_cmd     <= 1'b0;
            r_cmd_idx <= '0;
            r_col     <= '0;
            r_dig     <= '0;
            r_page    <= '0;
            r_last    <= 1'b0;
            r_snap    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_cmd     <= w_cmd_nxt;
            r_cmd_idx <= w_cmd_idx_nxt;
            r_col     <= w_col_nxt;
            r_dig     <= w_dig_nxt;
            r_page    <= w_page_nxt;
            r_last    <= w_last_nxt;
            r_snap    <= w_snap_nxt;
        end
    end

    assign tx.tx_data    = r_data;
    assign tx.tx_is_cmd  = r_cmd;
    assign tx.tx_valid   = r_valid;
    assign index_x       = r_col;
    assign index_y       = r_page;
    assign segments_out  = r_snap[r_dig*SEG_W +: SEG_W];
    assign busy          = (r_state == S_CMD) || (r_state == S_DATA);
    assign frame_done    = (r_state == S_DONE);
endmodule

// File: tb/tb_oled_digit_column_streamer.sv
// Directed bench for the OLED digit column streamer, with a decoder
// model that folds segments, page and column into each pixel byte.
module tb_oled_digit_column_streamer;
    localparam logic [47:0] SEG_A = {8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    localparam logic [47:0] SEG_B = {8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] segments_in = '0;
    logic [7:0]  segments_out;
    logic [4:0]  index_x;
    logic [1:0]  index_y;
    logic [7:0]  pixels_column_in;
    logic        busy;
    logic        frame_done;

    oled_digit_column_streamer_if tx_if ();

    oled_digit_column_streamer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .segments_in      (segments_in),
        .segments_out     (segments_out),
        .index_x          (index_x),
        .index_y          (index_y),
        .pixels_column_in (pixels_column_in),
        .tx               (tx_if),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    assign pixels_column_in = segments_out ^ {1'b0, index_y, index_x};

    typedef struct {
        int         k;
        logic [8:0] exp;
        string      name;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    int         stall_cnt = 0;
    bit         ready_rnd = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_byte = '0;
    logic [8:0] rx[$];
    vec_t       vecs[9];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_byte(int k, logic [47:0] segs);
        int         n;
        int         p;
        int         d;
        int         c;
        logic [7:0] s;
        case (k)
            0: return 9'h121;
            1: return 9'h100;
            2: return 9'h17D;
            3: return 9'h122;
            4: return 9'h100;
            5: return 9'h103;
            default: begin
                n = k - 6;
                p = n / 126;
                d = (n % 126) / 21;
                c = n % 21;
                s = segs[d*8 +: 8];
                return {1'b0, s ^ 8'(p * 32 + c)};
            end
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_cnt++;
                chk("stall_hold",
                    {tx_if.tx_valid, tx_if.tx_is_cmd, tx_if.tx_data},
                    {1'b1, prev_byte});
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_byte  = {tx_if.tx_is_cmd, tx_if.tx_data};
            if (tx_if.tx_valid && tx_if.tx_ready)
                rx.push_back({tx_if.tx_is_cmd, tx_if.tx_data});
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_if.tx_ready = ready_rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt != 0, 1);
    endtask

    task automatic wait_bytes(int cnt);
        int n = 0;
        while (rx.size() < cnt && n < 2000) begin
            tick();
            n++;
        end
        chk("bytes_reached", rx.size() >= cnt, 1);
    endtask

    task automatic check_stream(string name, logic [47:0] segs);
        int bk = -1;
        chk({name, "_len"}, rx.size(), 510);
        for (int k = 0; k < rx.size() && k < 510; k++) begin
            if (bk < 0 && rx[k] !== exp_byte(k, segs)) bk = k;
        end
        total++;
        if (bk >= 0) begin
            bad++;
            $display("FAIL %s: byte %0d got %0h want %0h",
                     name, bk, rx[bk], exp_byte(bk, segs));
        end
    endtask

    task automatic run_frame(logic [47:0] segs, bit rnd);
        rx.delete();
        done_cnt = 0;
        segments_in = segs;
        ready_rnd = rnd;
        pulse_start();
        wait_done(4000);
        tick();
        tick();
        ready_rnd = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0,   9'h121, "cmd_0x21"};
        vecs[1] = '{1,   9'h100, "cmd_col_start"};
        vecs[2] = '{2,   9'h17D, "cmd_col_end"};
        vecs[3] = '{5,   9'h103, "cmd_page_end"};
        vecs[4] = '{6,   9'h0A1, "data_p0_d0_c0"};
        vecs[5] = '{26,  9'h0B5, "data_p0_d0_c20"};
        vecs[6] = '{27,  9'h0B2, "data_p0_d1_c0"};
        vecs[7] = '{58,  9'h0C9, "data_p0_d2_c10"};
        vecs[8] = '{132, 9'h081, "data_p1_d0_c0"};

        #2;
        chk("por_outputs",
            {tx_if.tx_valid, tx_if.tx_is_cmd, tx_if.tx_data, busy,
             frame_done, index_x, index_y, segments_out}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        run_frame(SEG_A, 1'b0);
        for (int i = 0; i < 9; i++)
            chk(vecs[i].name, rx[vecs[i].k], vecs[i].exp);
        chk("data_p1_d0_c4", rx[136], 9'h085);
        chk("data_last", rx[509], 9'h082);
        chk("frame_cycles", done_cyc - start_cyc, 511);
        chk("done_once", done_cnt, 1);
        check_stream("stream_tied", SEG_A);

        stall_cnt = 0;
        run_frame(SEG_A, 1'b1);
        check_stream("stream_bp", SEG_A);
        chk("saw_stalls", stall_cnt > 20, 1);
        chk("done_once_bp", done_cnt, 1);

        rx.delete();
        done_cnt = 0;
        segments_in = SEG_B;
        pulse_start();
        wait_bytes(50);
        chk("pre_rst_valid", tx_if.tx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {tx_if.tx_valid, busy, frame_done}, 0);
        chk("async_rst_dec", {index_x, index_y, segments_out}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_after_rst", {tx_if.tx_valid, busy, frame_done}, 0);
        end
        chk("no_done_on_abort", done_cnt, 0);

        run_frame(SEG_B, 1'b0);
        check_stream("stream_after_rst", SEG_B);

        rx.delete();
        done_cnt = 0;
        segments_in = SEG_A;
        pulse_start();
        wait_bytes(106);
        segments_in = SEG_B;
        pulse_start();
        wait_done(2000);
        chk("done_high", frame_done, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("start_in_done_ignored", {tx_if.tx_valid, busy}, 0);
        end
        chk("single_done", done_cnt, 1);
        check_stream("stream_snapshot", SEG_A);

        run_frame(SEG_B, 1'b0);
        check_stream("stream_new_segs", SEG_B);
        chk("done_once_new", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
